// File: rtl/rom_display_scanner.sv
// ============================================================================
// rom_display_scanner : time-multiplexed multi-digit 7-segment driver with
//                       tear-free (frame-boundary) word commits.
// Optional: ROM_DISPLAY_LZ_BLANK_EN enables leading-zero suppression.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable_Display,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Data_In,
    output logic [6:0]              Data_Out,
    output logic [NUM_DIGITS-1:0]   Digit_Sel,
    output logic                    Frame_Done,
    output logic                    Pending
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int               WORD_W   = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_W-1:0]     active_q, active_d;
    logic [WORD_W-1:0]     pend_word_q, pend_word_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            data_out_q, data_out_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    logic       w_wrap;
    logic       w_boundary;
    logic [3:0] w_nibble;
    logic       w_lz_blank;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0011000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign w_wrap     = (cnt_q == CNT_LAST);
    assign w_boundary = w_wrap && (idx_q == IDX_LAST);
    assign w_nibble   = active_q[{idx_q, 2'b00} +: 4];

`ifdef ROM_DISPLAY_LZ_BLANK_EN
    // Walk down from the top digit; a zero is blank only while everything above it is 0 or 0xF.
    always_comb begin : lz_scan
        logic       hi_clear;
        logic [3:0] nib;
        hi_clear   = 1'b1;
        nib        = 4'h0;
        w_lz_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nib = active_q[4*i +: 4];
            if (idx_q == IDX_W'(i)) begin
                w_lz_blank = hi_clear && (nib == 4'h0);
            end
            hi_clear = hi_clear && ((nib == 4'h0) || (nib == 4'hF));
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        cnt_d        = w_wrap ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        active_d     = active_q;
        pend_word_d  = pend_word_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        if (w_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A Load on the boundary cycle bypasses the pending buffer entirely.
        if (w_boundary) begin
            if (Load) begin
                active_d = Data_In;
            end else if (pending_q) begin
                active_d = pend_word_q;
            end
            pending_d    = 1'b0;
            frame_done_d = Load || pending_q;
        end else if (Load) begin
            pend_word_d = Data_In;
            pending_d   = 1'b1;
        end

        // First cycle of each dwell is blanked to hide segment ghosting on digit change.
        data_out_d = SEG_OFF;
        if (Enable_Display && (cnt_q != '0) && !w_lz_blank) begin
            data_out_d = glyph(w_nibble);
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_sel_d[i] = !(Enable_Display && (idx_q == IDX_W'(i)));
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '1;
            pend_word_q  <= '1;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= SEG_OFF;
            digit_sel_q  <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_word_q  <= pend_word_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            data_out_q   <= data_out_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    assign Data_Out   = data_out_q;
    assign Digit_Sel  = digit_sel_q;
    assign Frame_Done = frame_done_q;
    assign Pending    = pending_q;

endmodule

`default_nettype wire
